// File: rtl/mux_arb_reg_pkg.sv
// rtl/mux_arb_reg_pkg.sv - shared mode encodings and width helper for mux_arb_reg
package mux_arb_reg_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Index width for n channels; never narrower than one bit
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_arb_reg_if.sv
// rtl/mux_arb_reg_if.sv - channel-side and sink-side handshake bundle for mux_arb_reg
interface mux_arb_reg_if #(
  parameter int NB   = 32,
  parameter int N_IN = 4
);
  import mux_arb_reg_pkg::*;

  localparam int NB_SELECT = sel_width(N_IN);

  logic [N_IN*NB-1:0]   i_data;
  logic [N_IN-1:0]      i_valid;
  logic [N_IN-1:0]      o_ready;
  logic [NB-1:0]        o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic [NB_SELECT-1:0] o_grant;

  // Selector side
  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_grant
  );

  // Sources and sink side
  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_grant
  );

endinterface

// File: rtl/mux_arb_reg_rr_priority_pick.sv
// rtl/mux_arb_reg_rr_priority_pick.sv - combinational round-robin winner search after last index
module rr_priority_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] winner_o,
  output logic         any_o
);

  // Scan from last+1 upward with wrap; the first requester found wins
  always_comb begin
    logic         found;
    int           idx;
    logic [W-1:0] idx_w;
    found    = 1'b0;
    idx      = 0;
    idx_w    = '0;
    winner_o = '0;
    for (int i = 1; i <= N; i++) begin
      idx   = (int'(last_i) + i) % N;
      idx_w = W'(idx);
      if (!found && req_i[idx_w]) begin
        winner_o = idx_w;
        found    = 1'b1;
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/mux_arb_reg.sv
// rtl/mux_arb_reg.sv - registered N-input selector, explicit select or round-robin
module mux_arb_reg
  import mux_arb_reg_pkg::*;
#(
  parameter int NB        = 32,
  parameter int N_IN      = 4,
  parameter int NB_SELECT = sel_width(N_IN)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_mode,
  input  logic [NB_SELECT-1:0] i_SEL,
  mux_arb_reg_if.slave         bus
);

  // Select index can address past N_IN; padding makes those slots read as not-valid
  localparam int N_PAD = 1 << NB_SELECT;

  logic [NB-1:0]        data_q,  data_d;
  logic [NB_SELECT-1:0] grant_q, grant_d;
  logic [NB_SELECT-1:0] last_q,  last_d;
  logic                 valid_q, valid_d;

  logic [NB_SELECT-1:0] rr_winner;
  logic                 rr_any;
  logic [N_PAD-1:0]     valid_pad;
  logic [NB_SELECT-1:0] cand;
  logic                 grant_ok;
  logic                 load_en;
  logic [NB-1:0]        sel_data;
  logic [N_IN-1:0]      ready_c;

  rr_priority_pick #(
    .N (N_IN),
    .W (NB_SELECT)
  ) u_pick (
    .req_i    (bus.i_valid),
    .last_i   (last_q),
    .winner_o (rr_winner),
    .any_o    (rr_any)
  );

  // Arbitration, accept strobes and next state of the output register
  always_comb begin
    valid_pad = N_PAD'(bus.i_valid);
    load_en   = ~valid_q | bus.i_ready;

    if (i_mode == MODE_RR) begin
      cand     = rr_winner;
      grant_ok = rr_any;
    end else begin
      cand     = i_SEL;
      grant_ok = valid_pad[i_SEL];
    end

    sel_data = '0;
    ready_c  = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (cand == NB_SELECT'(k)) begin
        sel_data   = bus.i_data[k*NB +: NB];
        ready_c[k] = ~i_reset & load_en & grant_ok;
      end
    end

    data_d  = data_q;
    grant_d = grant_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (load_en) begin
      if (grant_ok) begin
        data_d  = sel_data;
        grant_d = cand;
        last_d  = cand;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Output register and round-robin pointer; reset points last at N_IN-1 so channel 0 leads
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      data_q  <= '0;
      grant_q <= '0;
      last_q  <= NB_SELECT'(N_IN - 1);
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_ready = ready_c;
  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_grant = grant_q;

endmodule

// File: tb/tb_mux_arb_reg.sv
// tb/tb_mux_arb_reg.sv - directed vector table plus randomized reference-model check of mux_arb_reg
module tb_mux_arb_reg;

  localparam int NB   = 32;
  localparam int N_IN = 4;

  logic       i_clk;
  logic       i_reset;
  logic       i_mode;
  logic [1:0] i_SEL;

  mux_arb_reg_if #(.NB(NB), .N_IN(N_IN)) bus ();

  mux_arb_reg #(.NB(NB), .N_IN(N_IN)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_mode  (i_mode),
    .i_SEL   (i_SEL),
    .bus     (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic        ready;
    logic [3:0]  exp_ready;
    logic        exp_ov;
    logic [1:0]  exp_grant;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[21];

  // Reference model state: what the output register should hold, and the last winner
  logic        m_valid;
  logic [31:0] m_data;
  int          m_grant;
  int          m_last;

  logic [31:0] ch[4];

  initial begin
    logic [3:0]  e_ready;
    logic        ok;
    int          cand;
    logic        rst;
    logic [31:0] cd;

    vecs[0]  = '{1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 2'd2, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 32'hCAFE0002};
    vecs[2]  = '{1'b0, 1'b0, 2'd3, 4'h4, 1'b1, 4'h0, 1'b0, 2'd2, 32'hCAFE0002};
    vecs[3]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 32'hCAFE0003};
    vecs[4]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 32'hCAFE0000};
    vecs[5]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 32'hCAFE0001};
    vecs[6]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 32'hCAFE0002};
    vecs[7]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 32'hCAFE0003};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 32'hCAFE0000};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 32'hCAFE0000};
    vecs[10] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 32'hCAFE0000};
    vecs[11] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 32'hCAFE0000};
    vecs[12] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 32'hCAFE0001};
    vecs[13] = '{1'b0, 1'b1, 2'd0, 4'h9, 1'b1, 4'h8, 1'b1, 2'd3, 32'hCAFE0003};
    vecs[14] = '{1'b0, 1'b1, 2'd0, 4'h9, 1'b1, 4'h1, 1'b1, 2'd0, 32'hCAFE0000};
    vecs[15] = '{1'b0, 1'b0, 2'd0, 4'h9, 1'b1, 4'h1, 1'b1, 2'd0, 32'hCAFE0000};
    vecs[16] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 32'hCAFE0001};
    vecs[17] = '{1'b1, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0, 32'h0};
    vecs[18] = '{1'b0, 1'b1, 2'd0, 4'h6, 1'b1, 4'h2, 1'b1, 2'd1, 32'hCAFE0001};
    vecs[19] = '{1'b0, 1'b1, 2'd0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd1, 32'hCAFE0001};
    vecs[20] = '{1'b0, 1'b1, 2'd0, 4'h4, 1'b0, 4'h4, 1'b1, 2'd2, 32'hCAFE0002};

    i_reset     = 1'b1;
    i_mode      = 1'b0;
    i_SEL       = 2'd0;
    bus.i_valid = 4'h0;
    bus.i_ready = 1'b0;
    bus.i_data  = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};

    // Directed table: comb accept strobe before the edge, register contents after it
    for (int v = 0; v < 21; v++) begin
      @(negedge i_clk);
      i_reset     = vecs[v].rst;
      i_mode      = vecs[v].mode;
      i_SEL       = vecs[v].sel;
      bus.i_valid = vecs[v].valid;
      bus.i_ready = vecs[v].ready;
      #1;
      chk($sformatf("v%0d o_ready", v), 32'(bus.o_ready), 32'(vecs[v].exp_ready));
      @(posedge i_clk);
      #1;
      chk($sformatf("v%0d o_valid", v), 32'(bus.o_valid), 32'(vecs[v].exp_ov));
      chk($sformatf("v%0d o_grant", v), 32'(bus.o_grant), 32'(vecs[v].exp_grant));
      chk($sformatf("v%0d o_data", v),  bus.o_data,       vecs[v].exp_data);
    end

    // Randomized traffic against the rule-level model; first cycle is a reset to sync state
    m_valid = 1'b0; m_data = '0; m_grant = 0; m_last = 3;
    for (int t = 0; t < 2000; t++) begin
      @(negedge i_clk);
      rst = (t == 0) || ($urandom_range(0, 63) == 0);
      for (int k = 0; k < 4; k++) ch[k] = $urandom;
      i_reset     = rst;
      i_mode      = 1'($urandom_range(0, 1));
      i_SEL       = 2'($urandom_range(0, 3));
      bus.i_valid = 4'($urandom_range(0, 15));
      bus.i_ready = ($urandom_range(0, 3) != 0);
      bus.i_data  = {ch[3], ch[2], ch[1], ch[0]};

      cand = 0;
      ok   = 1'b0;
      if (i_mode == 1'b0) begin
        cand = int'(i_SEL);
        ok   = bus.i_valid[cand];
      end else begin
        for (int j = 1; j <= 4; j++) begin
          if (!ok && bus.i_valid[(m_last + j) % 4]) begin
            cand = (m_last + j) % 4;
            ok   = 1'b1;
          end
        end
      end
      e_ready = '0;
      if (!rst && ok && (!m_valid || bus.i_ready)) e_ready[cand] = 1'b1;
      cd = ch[cand];
      #1;
      chk($sformatf("r%0d o_ready", t), 32'(bus.o_ready), 32'(e_ready));

      if (rst) begin
        m_valid = 1'b0; m_data = '0; m_grant = 0; m_last = 3;
      end else if (!m_valid || bus.i_ready) begin
        if (ok) begin
          m_valid = 1'b1; m_data = cd; m_grant = cand; m_last = cand;
        end else begin
          m_valid = 1'b0;
        end
      end

      @(posedge i_clk);
      #1;
      chk($sformatf("r%0d o_valid", t), 32'(bus.o_valid), 32'(m_valid));
      chk($sformatf("r%0d o_grant", t), 32'(bus.o_grant), 32'(m_grant));
      chk($sformatf("r%0d o_data", t),  bus.o_data,       m_data);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
